// File: rtl/mem_arbiter.sv
// Purpose: round-robin sharing of one single-port memory between instruction fetch and load/store.
// Latency: accept -> mem_req next cycle -> response pulse 3 cycles after accept minimum; one access in flight.
// Backpressure: ready is offered only in IDLE to the selected requester; memory stalls are bounded by a watchdog.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              ireq_valid_i,
    output logic              ireq_ready_o,
    input  logic [XLEN-1:0]   ireq_addr_i,
    output logic              irsp_valid_o,
    output logic [XLEN-1:0]   irsp_data_o,
    output logic              irsp_err_o,
    input  logic              dreq_valid_i,
    output logic              dreq_ready_o,
    input  logic              dreq_we_i,
    input  logic [XLEN-1:0]   dreq_addr_i,
    input  logic [XLEN-1:0]   dreq_wdata_i,
    input  logic [XLEN/8-1:0] dreq_strb_i,
    output logic              drsp_valid_o,
    output logic [XLEN-1:0]   drsp_data_o,
    output logic              drsp_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_strb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    localparam int SW = XLEN / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
    state_t state_q, state_d;

    logic            owner_q;      // 1: data port owns the current access
    logic            last_data_q;  // 1: data port was granted last
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [SW-1:0]   strb_q;
    logic            irsp_valid_q, irsp_err_q, drsp_valid_q, drsp_err_q;
    logic [XLEN-1:0] irsp_data_q, drsp_data_q;

    logic            sel_i, sel_d, accept, misalign, done, abort;
    logic            rsp_fire, rsp_err, rsp_to_data;
    logic [XLEN-1:0] rsp_data;

    // Arbitration: only while idle; on a tie the port not granted last wins.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        if (state_q == IDLE) begin
            if (ireq_valid_i && dreq_valid_i) begin
                sel_d = !last_data_q;
                sel_i = last_data_q;
            end else begin
                sel_i = ireq_valid_i;
                sel_d = dreq_valid_i;
            end
        end
    end

    assign accept   = sel_i | sel_d;
    assign misalign = sel_i && (ireq_addr_i[1:0] != 2'b00);
    assign done     = (state_q == RESP) && mem_rvalid_i;
    // Last allowed cycle of the access went by without a completion.
    assign abort    = (state_q != IDLE) && !done && (cnt_q == CW'(TIMEOUT - 1));

    // Next state and the response to be registered for the owning port.
    always_comb begin
        state_d     = state_q;
        rsp_fire    = 1'b0;
        rsp_err     = 1'b0;
        rsp_to_data = owner_q;
        rsp_data    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        rsp_fire    = 1'b1;
                        rsp_err     = 1'b1;
                        rsp_to_data = 1'b0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (abort) begin
                    state_d  = IDLE;
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else if (mem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (abort) begin
                    state_d  = IDLE;
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else if (mem_rvalid_i) begin
                    state_d  = IDLE;
                    rsp_fire = 1'b1;
                    rsp_data = we_q ? '0 : mem_rdata_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Capture the winning request; fetches are forced to full-word reads.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            owner_q     <= 1'b0;
            last_data_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
        end else if (accept) begin
            owner_q     <= sel_d;
            last_data_q <= sel_d;
            we_q        <= sel_d & dreq_we_i;
            addr_q      <= sel_d ? dreq_addr_i : ireq_addr_i;
            wdata_q     <= sel_d ? dreq_wdata_i : '0;
            strb_q      <= sel_d ? dreq_strb_i : '1;
        end
    end

    // Watchdog: restarts when an access is launched, counts every busy cycle.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)                  cnt_q <= '0;
        else if (accept && !misalign) cnt_q <= '0;
        else if (state_q != IDLE)     cnt_q <= cnt_q + CW'(1);
    end

    // Response registers: single-cycle valid pulses, data/err held until the next response.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            irsp_valid_q <= 1'b0;
            irsp_err_q   <= 1'b0;
            irsp_data_q  <= '0;
            drsp_valid_q <= 1'b0;
            drsp_err_q   <= 1'b0;
            drsp_data_q  <= '0;
        end else begin
            irsp_valid_q <= 1'b0;
            drsp_valid_q <= 1'b0;
            if (rsp_fire) begin
                if (rsp_to_data) begin
                    drsp_valid_q <= 1'b1;
                    drsp_err_q   <= rsp_err;
                    drsp_data_q  <= rsp_data;
                end else begin
                    irsp_valid_q <= 1'b1;
                    irsp_err_q   <= rsp_err;
                    irsp_data_q  <= rsp_data;
                end
            end
        end
    end

    assign ireq_ready_o = sel_i;
    assign dreq_ready_o = sel_d;
    assign irsp_valid_o = irsp_valid_q;
    assign irsp_err_o   = irsp_err_q;
    assign irsp_data_o  = irsp_data_q;
    assign drsp_valid_o = drsp_valid_q;
    assign drsp_err_o   = drsp_err_q;
    assign drsp_data_o  = drsp_data_q;
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_strb_o   = strb_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed checks of mem_arbiter arbitration, memory handshake, watchdog and reset.
// Latency: inputs driven at negedge (or #1 after posedge), outputs sampled at negedge.
// Backpressure: memory gnt/rvalid are driven explicitly per scenario.
module tb_mem_arbiter;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            ireq_valid, ireq_ready_o, irsp_valid_o, irsp_err_o;
    logic [XLEN-1:0] ireq_addr, irsp_data_o;
    logic            dreq_valid, dreq_ready_o, dreq_we, drsp_valid_o, drsp_err_o;
    logic [XLEN-1:0] dreq_addr, dreq_wdata, drsp_data_o;
    logic [3:0]      dreq_strb, mem_strb_o;
    logic            mem_req_o, mem_we_o, mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .ireq_valid_i(ireq_valid), .ireq_ready_o(ireq_ready_o), .ireq_addr_i(ireq_addr),
        .irsp_valid_o(irsp_valid_o), .irsp_data_o(irsp_data_o), .irsp_err_o(irsp_err_o),
        .dreq_valid_i(dreq_valid), .dreq_ready_o(dreq_ready_o), .dreq_we_i(dreq_we),
        .dreq_addr_i(dreq_addr), .dreq_wdata_i(dreq_wdata), .dreq_strb_i(dreq_strb),
        .drsp_valid_o(drsp_valid_o), .drsp_data_o(drsp_data_o), .drsp_err_o(drsp_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    task automatic idle_inputs();
        ireq_valid = 0; ireq_addr = '0;
        dreq_valid = 0; dreq_we = 0; dreq_addr = '0; dreq_wdata = '0; dreq_strb = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({ireq_ready_o, dreq_ready_o, irsp_valid_o, drsp_valid_o, irsp_err_o, drsp_err_o, mem_req_o, mem_we_o} !== 8'h00) begin
            bad++; $display("FAIL %s_ctrl: got %b want 00000000", name,
                {ireq_ready_o, dreq_ready_o, irsp_valid_o, drsp_valid_o, irsp_err_o, drsp_err_o, mem_req_o, mem_we_o});
        end
        total++;
        if ({irsp_data_o, drsp_data_o, mem_addr_o, mem_wdata_o, mem_strb_o} !== '0) begin
            bad++; $display("FAIL %s_data: got %h want 0", name,
                {irsp_data_o, drsp_data_o, mem_addr_o, mem_wdata_o, mem_strb_o});
        end
    endtask

    task automatic test_reset();
        rstn = 0; idle_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        ireq_valid = 1; ireq_addr = 32'h100;
        #1;
        total++;
        if ({ireq_ready_o, dreq_ready_o} !== 2'b10) begin
            bad++; $display("FAIL fetch_ready: got %b want 10", {ireq_ready_o, dreq_ready_o});
        end
        @(negedge clk);  // cycle 1
        ireq_valid = 0; ireq_addr = '0;
        total++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'hf}) begin
            bad++; $display("FAIL fetch_mem_req: got %h want %h", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o},
                {1'b1, 1'b0, 32'h100, 32'h0, 4'hf});
        end
        mem_gnt = 1;
        @(negedge clk);  // cycle 2
        mem_gnt = 0;
        total++;
        if ({mem_req_o, irsp_valid_o} !== 2'b00) begin
            bad++; $display("FAIL fetch_req_pulse: got %b want 00", {mem_req_o, irsp_valid_o});
        end
        mem_rvalid = 1; mem_rdata = 32'h00500093;
        @(negedge clk);  // cycle 3
        mem_rvalid = 0; mem_rdata = '0;
        total++;
        if ({irsp_valid_o, irsp_err_o, drsp_valid_o, irsp_data_o} !== {3'b100, 32'h00500093}) begin
            bad++; $display("FAIL fetch_rsp: got %h want %h", {irsp_valid_o, irsp_err_o, drsp_valid_o, irsp_data_o},
                {3'b100, 32'h00500093});
        end
        @(negedge clk);
        total++;
        if ({irsp_valid_o, irsp_data_o} !== {1'b0, 32'h00500093}) begin
            bad++; $display("FAIL fetch_hold: got %h want %h", {irsp_valid_o, irsp_data_o}, {1'b0, 32'h00500093});
        end
    endtask

    task automatic test_misaligned();
        ireq_valid = 1; ireq_addr = 32'h102;
        @(negedge clk);
        ireq_valid = 0; ireq_addr = '0;
        total++;
        if ({mem_req_o, irsp_valid_o, irsp_err_o, irsp_data_o} !== {3'b011, 32'h0}) begin
            bad++; $display("FAIL misalign_rsp: got %h want %h", {mem_req_o, irsp_valid_o, irsp_err_o, irsp_data_o}, {3'b011, 32'h0});
        end
        @(negedge clk);
        total++;
        if ({mem_req_o, irsp_valid_o, irsp_err_o} !== 3'b001) begin
            bad++; $display("FAIL misalign_after: got %b want 001", {mem_req_o, irsp_valid_o, irsp_err_o});
        end
    endtask

    task automatic test_store();
        dreq_valid = 1; dreq_we = 1; dreq_addr = 32'h2000; dreq_wdata = 32'hDEADBEEF; dreq_strb = 4'b0011;
        #1;
        total++;
        if ({ireq_ready_o, dreq_ready_o} !== 2'b01) begin
            bad++; $display("FAIL store_ready: got %b want 01", {ireq_ready_o, dreq_ready_o});
        end
        @(negedge clk);  // cycle 1
        dreq_valid = 0; dreq_we = 0; dreq_addr = 32'hFFFF_FFFC; dreq_wdata = '0; dreq_strb = 4'hf;
        ireq_valid = 1; ireq_addr = 32'h500;
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o} !== {2'b11, 32'h2000, 32'hDEADBEEF, 4'b0011}) begin
                bad++; $display("FAIL store_stable c%0d: got %h want %h", c, {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_strb_o},
                    {2'b11, 32'h2000, 32'hDEADBEEF, 4'b0011});
            end
            total++;
            if (ireq_ready_o !== 1'b0) begin
                bad++; $display("FAIL store_busy_ready c%0d: got %b want 0", c, ireq_ready_o);
            end
            if (c == 3) begin mem_gnt = 1; ireq_valid = 0; ireq_addr = '0; end
            @(negedge clk);
        end
        mem_gnt = 0;
        total++;
        if (mem_req_o !== 1'b0) begin
            bad++; $display("FAIL store_req_drop: got %b want 0", mem_req_o);
        end
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = '0; dreq_addr = '0; dreq_strb = '0;
        total++;
        if ({drsp_valid_o, drsp_err_o, irsp_valid_o, drsp_data_o} !== {3'b100, 32'h0}) begin
            bad++; $display("FAIL store_rsp: got %h want %h", {drsp_valid_o, drsp_err_o, irsp_valid_o, drsp_data_o}, {3'b100, 32'h0});
        end
    endtask

    task automatic test_timeout();
        dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h3000;
        @(negedge clk);  // cycle 1
        dreq_valid = 0; dreq_addr = '0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            total++;
            if ({mem_req_o, drsp_valid_o} !== 2'b10) begin
                bad++; $display("FAIL timeout_wait c%0d: got %b want 10", c, {mem_req_o, drsp_valid_o});
            end
            @(negedge clk);
        end
        total++;
        if ({mem_req_o, drsp_valid_o, drsp_err_o, drsp_data_o} !== {3'b011, 32'h0}) begin
            bad++; $display("FAIL timeout_rsp: got %h want %h", {mem_req_o, drsp_valid_o, drsp_err_o, drsp_data_o}, {3'b011, 32'h0});
        end
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        total++;
        if ({mem_req_o, drsp_valid_o, irsp_valid_o, drsp_data_o} !== {3'b000, 32'h0}) begin
            bad++; $display("FAIL timeout_late: got %h want %h", {mem_req_o, drsp_valid_o, irsp_valid_o, drsp_data_o}, {3'b000, 32'h0});
        end
        ireq_valid = 1; ireq_addr = 32'h104;
        #1;
        total++;
        if (ireq_ready_o !== 1'b1) begin
            bad++; $display("FAIL after_timeout_ready: got %b want 1", ireq_ready_o);
        end
        @(negedge clk);
        ireq_valid = 0; ireq_addr = '0;
        total++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h104}) begin
            bad++; $display("FAIL after_timeout_req: got %h want %h", {mem_req_o, mem_addr_o}, {1'b1, 32'h104});
        end
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = '0;
        total++;
        if ({irsp_valid_o, irsp_err_o, drsp_valid_o, irsp_data_o} !== {3'b100, 32'hCAFEF00D}) begin
            bad++; $display("FAIL after_timeout_rsp: got %h want %h", {irsp_valid_o, irsp_err_o, drsp_valid_o, irsp_data_o},
                {3'b100, 32'hCAFEF00D});
        end
    endtask

    // Granted at once, then the memory never completes: the watchdog must still fire.
    task automatic test_timeout_resp();
        dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h3004;
        @(negedge clk);  // cycle 1
        dreq_valid = 0; dreq_addr = '0; mem_gnt = 1;
        @(negedge clk);  // cycle 2
        mem_gnt = 0;
        repeat (TIMEOUT - 2) @(negedge clk);  // cycle 16
        total++;
        if ({mem_req_o, drsp_valid_o} !== 2'b00) begin
            bad++; $display("FAIL timeout_resp_wait: got %b want 00", {mem_req_o, drsp_valid_o});
        end
        @(negedge clk);  // cycle 17
        total++;
        if ({drsp_valid_o, drsp_err_o, drsp_data_o} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL timeout_resp_rsp: got %h want %h", {drsp_valid_o, drsp_err_o, drsp_data_o}, {2'b11, 32'h0});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gseq = '0;
        logic [3:0] rseq = '0;
        int ng = 0;
        int nr = 0;
        logic rv_pend = 1'b0;
        rstn = 0; idle_inputs();
        repeat (2) @(negedge clk);
        rstn = 1;
        ireq_addr = 32'h400; dreq_addr = 32'h800; dreq_we = 0;
        for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
            @(posedge clk); #1;
            ireq_valid = (ng < 4); dreq_valid = (ng < 4);
            mem_rvalid = rv_pend; mem_rdata = 32'h1000 + nr;
            mem_gnt = mem_req_o; rv_pend = mem_gnt;
            @(negedge clk);
            total++;
            if ((irsp_valid_o && drsp_valid_o) || (ireq_ready_o && dreq_ready_o)) begin
                bad++; $display("FAIL rr_exclusive cyc%0d: got rsp=%b rdy=%b", cyc,
                    {irsp_valid_o, drsp_valid_o}, {ireq_ready_o, dreq_ready_o});
            end
            if (ng < 4 && (dreq_ready_o || ireq_ready_o)) begin gseq[ng] = dreq_ready_o; ng++; end
            if (nr < 4 && (drsp_valid_o || irsp_valid_o)) begin rseq[nr] = drsp_valid_o; nr++; end
        end
        idle_inputs();
        total++;
        if (ng != 4 || nr != 4) begin
            bad++; $display("FAIL rr_count: got grants=%0d rsps=%0d want 4 4", ng, nr);
        end
        total++;
        if (gseq !== 4'b0101) begin
            bad++; $display("FAIL rr_grant_order: got %b want 0101 (bit0 first, 1=data)", gseq);
        end
        total++;
        if (rseq !== 4'b0101) begin
            bad++; $display("FAIL rr_rsp_order: got %b want 0101 (bit0 first, 1=data)", rseq);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h600;
        @(negedge clk);  // REQ
        dreq_valid = 0; dreq_addr = '0; mem_gnt = 1;
        @(negedge clk);  // RESP
        mem_gnt = 0; rstn = 0;
        @(negedge clk);
        check_all_zero("reset_mid");
        rstn = 1;
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = '0;
        total++;
        if ({irsp_valid_o, drsp_valid_o, mem_req_o, drsp_data_o} !== {3'b000, 32'h0}) begin
            bad++; $display("FAIL reset_mid_no_rsp: got %h want %h", {irsp_valid_o, drsp_valid_o, mem_req_o, drsp_data_o}, {3'b000, 32'h0});
        end
        ireq_valid = 1; ireq_addr = 32'h700; dreq_valid = 1; dreq_addr = 32'h704;
        #1;
        total++;
        if ({ireq_ready_o, dreq_ready_o} !== 2'b01) begin
            bad++; $display("FAIL reset_mid_tie: got %b want 01", {ireq_ready_o, dreq_ready_o});
        end
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_misaligned();
        test_store();
        test_timeout();
        test_timeout_resp();
        test_round_robin();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
